alu_reservation_station: RTL and testbench

- Receiving end of the dispatch-to-ALU interface. It accepts ALU_RS_input_struct_t packets from the dispatch unit and buffers them in RS_DEPTH entries.
- Each cycle it snoops two writeback tag buses to wake up pending source operands. It issues the oldest ready entry to one ALU pipeline through a valid/ready handshake.
- It accepts single-entry kill jobs from the ROB during restore.
- One instance sits in front of each ALU (ALU_0, ALU_1).

---
 rtl/alu_reservation_station.sv | 197 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Purpose : ALU reservation station; buffers dispatched ops, wakes operands from two WB tag buses, issues oldest ready op.
// Latency : dispatch-to-issue >= 1 cycle (no bypass); a writeback wakes an operand for issue on the following cycle.
// Backpres: dispatch_ready drops when all RS_DEPTH slots are full (no credit for a same-cycle issue); issue holds while issue_ready=0.
//
// Ports:
//   CLK, nRST                         clock (rising edge), asynchronous active-low reset
//   dispatch_valid/_ready/_struct     48-bit packet from dispatch:
//                                     {op[3:0], itype, src0{needed,ready,tag[5:0]}, src1{..}, dest[5:0], imm16, ROB_index[4:0]}
//   WB0_valid/_phys_reg_tag           writeback broadcast, port 0
//   WB1_valid/_phys_reg_tag           writeback broadcast, port 1
//   kill_valid, kill_ROB_index        single-entry squash from the ROB
//   issue_valid/_ready, issue_*       selected packet toward the ALU pipeline
module alu_reservation_station #(
    parameter int RS_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dispatch_valid,
    output logic        dispatch_ready,
    input  logic [47:0] dispatch_struct,
    input  logic        WB0_valid,
    input  logic [5:0]  WB0_phys_reg_tag,
    input  logic        WB1_valid,
    input  logic [5:0]  WB1_phys_reg_tag,
    input  logic        kill_valid,
    input  logic [4:0]  kill_ROB_index,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [3:0]  issue_op,
    output logic        issue_itype,
    output logic [5:0]  issue_source_0_tag,
    output logic [5:0]  issue_source_1_tag,
    output logic [5:0]  issue_dest_phys_reg_tag,
    output logic [15:0] issue_imm16,
    output logic [4:0]  issue_ROB_index
);

    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic       needed;
        logic       ready;
        logic [5:0] tag;
    } src_t;

    typedef struct packed {
        logic [3:0]  op;
        logic        itype;
        src_t        source_0;
        src_t        source_1;
        logic [5:0]  dest_phys_reg_tag;
        logic [15:0] imm16;
        logic [4:0]  ROB_index;
    } alu_rs_input_struct_t;

    typedef struct packed {
        logic                 valid;
        alu_rs_input_struct_t pkt;
    } entry_t;

    // Slot 0 is always the oldest entry; valid slots are kept contiguous from 0.
    entry_t        slots [RS_DEPTH];
    logic [CW-1:0] count;

    entry_t        nxt   [RS_DEPTH];
    entry_t        woken [RS_DEPTH];
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] kept;

    logic [RS_DEPTH-1:0] kill_hit;
    logic [RS_DEPTH-1:0] elig;
    logic [RS_DEPTH-1:0] remove;
    logic [IW-1:0]       sel;
    logic                found;
    logic                accept;
    logic                fire;
    alu_rs_input_struct_t new_pkt;

    // A source needing a tag becomes ready when either writeback port broadcasts that tag.
    function automatic src_t wake_src(input src_t s,
                                      input logic w0v, input logic [5:0] w0t,
                                      input logic w1v, input logic [5:0] w1t);
        src_t r;
        r = s;
        if (s.needed && ((w0v && (w0t == s.tag)) || (w1v && (w1t == s.tag))))
            r.ready = 1'b1;
        return r;
    endfunction

    function automatic logic src_ok(input src_t s);
        return !s.needed || s.ready;
    endfunction

    assign dispatch_ready = (count < CW'(RS_DEPTH));
    assign accept         = dispatch_valid && dispatch_ready;

    // Eligibility uses registered ready bits only, so a wakeup never issues in its own cycle.
    // A slot being killed this cycle is masked out so it cannot also be issued.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            kill_hit[i] = kill_valid && slots[i].valid &&
                          (slots[i].pkt.ROB_index == kill_ROB_index);
            elig[i]     = slots[i].valid &&
                          src_ok(slots[i].pkt.source_0) &&
                          src_ok(slots[i].pkt.source_1) &&
                          !kill_hit[i];
        end
    end

    // Oldest-first pick: lowest-index eligible slot.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (elig[i] && !found) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign issue_valid = found;
    assign fire        = issue_valid && issue_ready;

    assign issue_op                = issue_valid ? slots[sel].pkt.op                : '0;
    assign issue_itype             = issue_valid ? slots[sel].pkt.itype             : 1'b0;
    assign issue_source_0_tag      = issue_valid ? slots[sel].pkt.source_0.tag      : '0;
    assign issue_source_1_tag      = issue_valid ? slots[sel].pkt.source_1.tag      : '0;
    assign issue_dest_phys_reg_tag = issue_valid ? slots[sel].pkt.dest_phys_reg_tag : '0;
    assign issue_imm16             = issue_valid ? slots[sel].pkt.imm16             : '0;
    assign issue_ROB_index         = issue_valid ? slots[sel].pkt.ROB_index         : '0;

    // Per-slot removal: issued slot and/or killed slot (never the same one).
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++)
            remove[i] = kill_hit[i] || (fire && (sel == IW'(i)));
    end

    // Apply this cycle's writeback broadcasts to resident entries.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            woken[i]              = slots[i];
            woken[i].pkt.source_0 = wake_src(slots[i].pkt.source_0,
                                             WB0_valid, WB0_phys_reg_tag,
                                             WB1_valid, WB1_phys_reg_tag);
            woken[i].pkt.source_1 = wake_src(slots[i].pkt.source_1,
                                             WB0_valid, WB0_phys_reg_tag,
                                             WB1_valid, WB1_phys_reg_tag);
        end
    end

    // Incoming packet also sees same-cycle writebacks so it is not left waiting forever.
    always_comb begin
        new_pkt          = alu_rs_input_struct_t'(dispatch_struct);
        new_pkt.source_0 = wake_src(new_pkt.source_0,
                                    WB0_valid, WB0_phys_reg_tag,
                                    WB1_valid, WB1_phys_reg_tag);
        new_pkt.source_1 = wake_src(new_pkt.source_1,
                                    WB0_valid, WB0_phys_reg_tag,
                                    WB1_valid, WB1_phys_reg_tag);
    end

    // Collapse: surviving entries are packed down in age order, then the new
    // packet lands in the first free slot. kept never reaches RS_DEPTH when an
    // accept happens because accept requires count < RS_DEPTH.
    always_comb begin
        for (int j = 0; j < RS_DEPTH; j++)
            nxt[j] = '0;
        kept = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (slots[i].valid && !remove[i]) begin
                nxt[kept[IW-1:0]] = woken[i];
                kept              = kept + CW'(1);
            end
        end
        if (accept) begin
            nxt[kept[IW-1:0]].valid = 1'b1;
            nxt[kept[IW-1:0]].pkt   = new_pkt;
        end
        // Equals count + accept - issued - killed.
        count_nxt = kept + CW'(accept);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RS_DEPTH; i++)
                slots[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++)
                slots[i] <= nxt[i];
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;

    logic        CLK;
    logic        nRST;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [47:0] dispatch_struct;
    logic        WB0_valid;
    logic [5:0]  WB0_phys_reg_tag;
    logic        WB1_valid;
    logic [5:0]  WB1_phys_reg_tag;
    logic        kill_valid;
    logic [4:0]  kill_ROB_index;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_op;
    logic        issue_itype;
    logic [5:0]  issue_source_0_tag;
    logic [5:0]  issue_source_1_tag;
    logic [5:0]  issue_dest_phys_reg_tag;
    logic [15:0] issue_imm16;
    logic [4:0]  issue_ROB_index;

    int n_vec  = 0;
    int n_miss = 0;

    logic [47:0] exp_q [$];
    logic [47:0] mon_e;
    logic [43:0] mon_exp;
    logic [43:0] mon_act;

    alu_reservation_station #(.RS_DEPTH(4)) dut (
        .CLK                     (CLK),
        .nRST                    (nRST),
        .dispatch_valid          (dispatch_valid),
        .dispatch_ready          (dispatch_ready),
        .dispatch_struct         (dispatch_struct),
        .WB0_valid               (WB0_valid),
        .WB0_phys_reg_tag        (WB0_phys_reg_tag),
        .WB1_valid               (WB1_valid),
        .WB1_phys_reg_tag        (WB1_phys_reg_tag),
        .kill_valid              (kill_valid),
        .kill_ROB_index          (kill_ROB_index),
        .issue_valid             (issue_valid),
        .issue_ready             (issue_ready),
        .issue_op                (issue_op),
        .issue_itype             (issue_itype),
        .issue_source_0_tag      (issue_source_0_tag),
        .issue_source_1_tag      (issue_source_1_tag),
        .issue_dest_phys_reg_tag (issue_dest_phys_reg_tag),
        .issue_imm16             (issue_imm16),
        .issue_ROB_index         (issue_ROB_index)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [47:0] pk(input logic [3:0] op, input logic itype,
                                       input logic n0, input logic r0, input logic [5:0] t0,
                                       input logic n1, input logic r1, input logic [5:0] t1,
                                       input logic [5:0] dest, input logic [15:0] imm,
                                       input logic [4:0] rob);
        return {op, itype, n0, r0, t0, n1, r1, t1, dest, imm, rob};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the next expected packet.
    always @(negedge CLK) begin
        if (nRST && issue_valid && issue_ready) begin
            n_vec++;
            mon_act = {issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
                       issue_dest_phys_reg_tag, issue_imm16, issue_ROB_index};
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_issue: got 0x%0h expected no issue", mon_act);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_exp = {mon_e[47:44], mon_e[43], mon_e[40:35], mon_e[32:27],
                           mon_e[26:21], mon_e[20:5], mon_e[4:0]};
                if (mon_act !== mon_exp) begin
                    n_miss++;
                    $display("FAIL issue_packet: got 0x%0h expected 0x%0h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST             = 1'b0;
        dispatch_valid   = 1'b0;
        dispatch_struct  = '0;
        WB0_valid        = 1'b0;
        WB0_phys_reg_tag = '0;
        WB1_valid        = 1'b0;
        WB1_phys_reg_tag = '0;
        kill_valid       = 1'b0;
        kill_ROB_index   = '0;
        issue_ready      = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("rst_issue_dest", 32'(issue_dest_phys_reg_tag), 32'd0);
        chk("rst_issue_imm", 32'(issue_imm16), 32'd0);
        nRST = 1'b1;

        // 1: ready ADDI issues the cycle after accept, then queue is empty
        dispatch_valid  = 1'b1;
        dispatch_struct = pk(ALU_ADD, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 6'd40, 16'h0004, 5'd3);
        issue_ready     = 1'b1;
        exp_q.push_back(dispatch_struct);
        @(negedge CLK);
        chk("t1_no_bypass", 32'(issue_valid), 32'd0);
        step();
        dispatch_valid = 1'b0;
        @(negedge CLK);
        chk("t1_issue_valid", 32'(issue_valid), 32'd1);
        chk("t1_dest", 32'(issue_dest_phys_reg_tag), 32'd40);
        chk("t1_imm", 32'(issue_imm16), 32'h0004);
        chk("t1_rob", 32'(issue_ROB_index), 32'd3);
        step();
        @(negedge CLK);
        chk("t1_empty_after", 32'(issue_valid), 32'd0);

        // 2: waiting source woken by WB1 two cycles later
        step();
        dispatch_valid  = 1'b1;
        dispatch_struct = pk(ALU_SUB, 1'b0, 1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 6'd0, 6'd41, 16'h1234, 5'd9);
        exp_q.push_back(dispatch_struct);
        step();
        dispatch_valid = 1'b0;
        @(negedge CLK);
        chk("t2_wait_c1", 32'(issue_valid), 32'd0);
        step();
        WB1_valid        = 1'b1;
        WB1_phys_reg_tag = 6'd12;
        @(negedge CLK);
        chk("t2_no_same_cycle_wake", 32'(issue_valid), 32'd0);
        step();
        WB1_valid = 1'b0;
        @(negedge CLK);
        chk("t2_issue_after_wb", 32'(issue_valid), 32'd1);
        chk("t2_src0_tag", 32'(issue_source_0_tag), 32'd12);
        step();
        @(negedge CLK);
        chk("t2_empty_after", 32'(issue_valid), 32'd0);

        // 3: dispatch/writeback race on source 1
        step();
        dispatch_valid   = 1'b1;
        dispatch_struct  = pk(ALU_AND, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd20, 6'd42, 16'h00ff, 5'd10);
        WB0_valid        = 1'b1;
        WB0_phys_reg_tag = 6'd20;
        exp_q.push_back(dispatch_struct);
        step();
        dispatch_valid = 1'b0;
        WB0_valid      = 1'b0;
        @(negedge CLK);
        chk("t3_race_issue", 32'(issue_valid), 32'd1);
        chk("t3_src1_tag", 32'(issue_source_1_tag), 32'd20);
        step();

        // 4: fill, full backpressure, in-order drain
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            dispatch_valid  = 1'b1;
            dispatch_struct = pk(ALU_ADD, 1'b0, 1'b0, 1'b0, 6'(i), 1'b0, 1'b0, 6'd0,
                                 6'(i + 50), 16'(i * 16), 5'(i));
            exp_q.push_back(dispatch_struct);
            step();
        end
        dispatch_struct = pk(ALU_ADD, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd55, 16'h0055, 5'd5);
        @(negedge CLK);
        chk("t4_full_not_ready", 32'(dispatch_ready), 32'd0);
        chk("t4_oldest_rob", 32'(issue_ROB_index), 32'd1);
        step();
        dispatch_valid = 1'b0;
        issue_ready    = 1'b1;
        @(negedge CLK);
        chk("t4_no_issue_credit", 32'(dispatch_ready), 32'd0);
        step();
        @(negedge CLK);
        chk("t4_ready_after_issue", 32'(dispatch_ready), 32'd1);
        step();
        step();
        step();
        @(negedge CLK);
        chk("t4_fifth_dropped", 32'(issue_valid), 32'd0);

        // 5: kill oldest while issuing
        step();
        issue_ready = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            dispatch_valid  = 1'b1;
            dispatch_struct = pk(ALU_SUB, 1'b1, 1'b1, 1'b1, 6'(i), 1'b0, 1'b0, 6'd0,
                                 6'(i + 20), 16'(i), 5'(i));
            if (i != 6)
                exp_q.push_back(dispatch_struct);
            step();
        end
        dispatch_valid = 1'b0;
        kill_valid     = 1'b1;
        kill_ROB_index = 5'd6;
        issue_ready    = 1'b1;
        @(negedge CLK);
        chk("t5_kill_issue_valid", 32'(issue_valid), 32'd1);
        chk("t5_kill_issue_rob", 32'(issue_ROB_index), 32'd7);
        step();
        kill_valid  = 1'b0;
        issue_ready = 1'b0;
        @(negedge CLK);
        chk("t5_slot0_rob", 32'(issue_ROB_index), 32'd8);
        step();
        issue_ready = 1'b1;
        step();
        @(negedge CLK);
        chk("t5_empty_after", 32'(issue_valid), 32'd0);

        // 6: asynchronous reset mid-cycle with 3 entries held
        step();
        issue_ready = 1'b0;
        for (int i = 11; i <= 13; i++) begin
            dispatch_valid  = 1'b1;
            dispatch_struct = pk(ALU_ADD, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0,
                                 6'(i), 16'(i), 5'(i));
            step();
        end
        dispatch_valid = 1'b0;
        @(negedge CLK);
        chk("t6_held_valid", 32'(issue_valid), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("t6_rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("t6_rst_rob", 32'(issue_ROB_index), 32'd0);
        step();
        nRST        = 1'b1;
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_no_stale_issue", 32'(issue_valid), 32'd0);
            step();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
